// File: rtl/rx_cmd_sched.sv
`default_nettype none
//==============================================================================
// rx_cmd_sched : device-filtered command FIFO issuing req/ack config writes
// Rev 1.0
//==============================================================================
module rx_cmd_sched #(
   parameter logic [7:0] DEV_ID     = 8'h01,
   parameter int         FIFO_DEPTH = 4,
   parameter int         TIMEOUT_US = 1000
) (
   input  logic       i_clk_sys,
   input  logic       i_rst,
   input  logic       i_pluse_us,
   input  logic [7:0] i_cmdr_dev,
   input  logic [7:0] i_cmdr_mod,
   input  logic [7:0] i_cmdr_addr,
   input  logic [7:0] i_cmdr_data,
   input  logic       i_cmdr_vld,
   output logic [7:0] o_cfg_mod,
   output logic [7:0] o_cfg_addr,
   output logic [7:0] o_cfg_data,
   output logic       o_cfg_req,
   input  logic       i_cfg_ack,
   output logic       o_busy,
   output logic [7:0] o_ovf_cnt,
   output logic [7:0] o_tmo_cnt
);

   localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] c_depth    = CW'(FIFO_DEPTH);
   localparam logic [15:0]   c_tmo_last = 16'(TIMEOUT_US - 1);
   localparam logic [7:0]    c_bcast    = 8'hFF;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

   logic [23:0]   r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [CW-1:0] r_count;
   state_t        r_state;
   logic [15:0]   r_us;
   logic [7:0]    r_mod;
   logic [7:0]    r_addr;
   logic [7:0]    r_data;
   logic          r_req;
   logic          r_busy;
   logic [7:0]    r_ovf;
   logic [7:0]    r_tmo;

   logic          w_accept;
   logic          w_pop;
   logic          w_push;
   logic          w_drop;
   logic          w_active_nxt;
   logic [CW-1:0] w_count_nxt;

   assign w_accept    = i_cmdr_vld && ((i_cmdr_dev == DEV_ID) || (i_cmdr_dev == c_bcast));
   assign w_pop       = (r_state == ST_IDLE) && (r_count != '0);
   // A full FIFO still accepts when the head leaves in the same cycle.
   assign w_push      = w_accept && ((r_count < c_depth) || w_pop);
   assign w_drop      = w_accept && !w_push;
   assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
   // Next state is non-IDLE when leaving IDLE with a pop or anywhere in REQ (REQ goes to REQ or GAP).
   assign w_active_nxt = w_pop || (r_state == ST_REQ);

   always_ff @(posedge i_clk_sys) begin
      if (w_push) begin
         r_mem[r_wptr] <= {i_cmdr_mod, i_cmdr_addr, i_cmdr_data};
      end
   end

   always_ff @(posedge i_clk_sys) begin
      if (i_rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         r_state <= ST_IDLE;
         r_us    <= '0;
         r_mod   <= '0;
         r_addr  <= '0;
         r_data  <= '0;
         r_req   <= 1'b0;
         r_busy  <= 1'b0;
         r_ovf   <= '0;
         r_tmo   <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + AW'(1);
         if (w_pop)  r_rptr <= r_rptr + AW'(1);
         r_count <= w_count_nxt;
         r_busy  <= (w_count_nxt != '0) || w_active_nxt;
         if (w_drop && (r_ovf != 8'hFF)) r_ovf <= r_ovf + 8'd1;

         case (r_state)
            ST_IDLE: begin
               if (w_pop) begin
                  {r_mod, r_addr, r_data} <= r_mem[r_rptr];
                  r_us    <= '0;
                  r_req   <= 1'b1;
                  r_state <= ST_REQ;
               end
            end
            ST_REQ: begin
               if (i_cfg_ack) begin
                  r_req   <= 1'b0;
                  r_state <= ST_GAP;
               end else if (i_pluse_us) begin
                  if (r_us == c_tmo_last) begin
                     r_req   <= 1'b0;
                     r_state <= ST_GAP;
                     if (r_tmo != 8'hFF) r_tmo <= r_tmo + 8'd1;
                  end else begin
                     r_us <= r_us + 16'd1;
                  end
               end
            end
            ST_GAP:  r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign o_cfg_mod  = r_mod;
   assign o_cfg_addr = r_addr;
   assign o_cfg_data = r_data;
   assign o_cfg_req  = r_req;
   assign o_busy     = r_busy;
   assign o_ovf_cnt  = r_ovf;
   assign o_tmo_cnt  = r_tmo;

endmodule
`default_nettype wire
